// File: rtl/dial_angle_encoder.sv
// Dial angle encoder: digital strobe-paced rotation plus analog spinner deltas into one wrapping position.
// Optional hold-acceleration of the digital rate when DIAL_ACCEL_EN is defined.
module dial_angle_encoder #(
   parameter int unsigned OUT_W     = 4,
   parameter int unsigned FRAC_W    = 4,
   parameter int unsigned SLOW_RATE = 8,
   parameter int unsigned FAST_RATE = 16,
   parameter int unsigned SPIN_SHL  = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             fast,
   input  logic             minus,
   input  logic             plus,
   input  logic             strobe,
   input  logic [8:0]       spin_in,
   input  logic             zero,
   output logic [OUT_W-1:0] spin_out
);

   localparam int unsigned ACC_W = OUT_W + FRAC_W;
   localparam int unsigned SUM_W = ACC_W + 2;

   logic [ACC_W-1:0]        acc;
   logic [ACC_W-1:0]        acc_nxt;
   logic                    strobe_d;
   logic                    tog_d;
   logic                    armed;
   logic                    strobe_edge;
   logic                    dir_up;
   logic                    dir_dn;
   logic signed [SUM_W-1:0] rate;
   logic signed [SUM_W-1:0] d_dig;
   logic signed [SUM_W-1:0] d_sp;

   assign strobe_edge = strobe & ~strobe_d;
   assign dir_up      = plus & ~minus;
   assign dir_dn      = minus & ~plus;
   assign spin_out    = acc[ACC_W-1:FRAC_W];

`ifdef DIAL_ACCEL_EN
   logic [4:0] hold_cnt;
   logic [4:0] cnt_nxt;
   logic [1:0] dir;
   logic [1:0] prev_dir;
   logic [1:0] lvl;

   // Level is taken from the post-edge count so the 9th held edge already steps double.
   always_comb begin
      dir     = {dir_dn, dir_up};
      cnt_nxt = hold_cnt;
      if (dir == 2'b00) begin
         cnt_nxt = '0;
      end else if (strobe_edge) begin
         if (dir != prev_dir)
            cnt_nxt = '0;
         else if (hold_cnt != '1)
            cnt_nxt = hold_cnt + 5'd1;
      end
      if (cnt_nxt >= 5'd16)
         lvl = 2'd2;
      else if (cnt_nxt >= 5'd8)
         lvl = 2'd1;
      else
         lvl = 2'd0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_cnt <= '0;
         prev_dir <= '0;
      end else begin
         hold_cnt <= cnt_nxt;
         if (strobe_edge)
            prev_dir <= dir;
      end
   end
`endif

   always_comb begin
      rate = fast ? SUM_W'(FAST_RATE) : SUM_W'(SLOW_RATE);
`ifdef DIAL_ACCEL_EN
      rate = rate << lvl;
`endif
      d_dig = '0;
      if (strobe_edge && dir_up)
         d_dig = rate;
      else if (strobe_edge && dir_dn)
         d_dig = -rate;
      d_sp = '0;
      if (armed && (spin_in[8] != tog_d))
         d_sp = {{(SUM_W-8){spin_in[7]}}, spin_in[7:0]} << SPIN_SHL;
      // Sum carries two guard bits; truncation gives wrap in both directions.
      acc_nxt = ACC_W'(signed'({2'b00, acc}) + d_dig + d_sp);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc      <= '0;
         strobe_d <= 1'b0;
         tog_d    <= 1'b0;
         armed    <= 1'b0;
      end else begin
         strobe_d <= strobe;
         tog_d    <= spin_in[8];
         armed    <= 1'b1;
         acc      <= zero ? '0 : acc_nxt;
      end
   end

endmodule

// File: tb/tb_dial_angle_encoder.sv
// Scoreboard bench for dial_angle_encoder: directed stimulus pushes expected angles, a monitor pops and compares.
`timescale 1ns/1ps
module tb_dial_angle_encoder;

   logic       clk;
   logic       reset_n;
   logic       fast;
   logic       minus;
   logic       plus;
   logic       strobe;
   logic [8:0] spin_in;
   logic       zero;
   logic [3:0] spin_out;

   typedef struct {
      string      name;
      logic [3:0] val;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   logic tog    = 1'b0;

   dial_angle_encoder dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .fast     (fast),
      .minus    (minus),
      .plus     (plus),
      .strobe   (strobe),
      .spin_in  (spin_in),
      .zero     (zero),
      .spin_out (spin_out)
   );

   initial clk = 1'b0;
   always #12.5 clk = ~clk;

   // Monitor: outputs are sampled on the falling edge, away from the active edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (spin_out !== e.val) begin
               errors++;
               $display("FAIL %s: spin_out=%0d expected %0d", e.name, spin_out, e.val);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [3:0] v);
      exp_t        e;
      int unsigned n;
      @(negedge clk);
      e.name = name;
      e.val  = v;
      sb.push_back(e);
      n = 0;
      while (sb.size() != 0 && n < 8) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s: monitor timeout, expected %0d", name, v);
         sb.delete();
      end
   endtask

   task automatic pulse();
      @(negedge clk) strobe = 1'b1;
      @(negedge clk) strobe = 1'b0;
   endtask

   task automatic pulses(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) pulse();
   endtask

   task automatic spin(input logic [7:0] delta);
      @(negedge clk);
      tog     = ~tog;
      spin_in = {tog, delta};
   endtask

   task automatic do_reset(input string name);
      @(negedge clk);
      reset_n = 1'b0;
      plus    = 1'b0;
      minus   = 1'b0;
      fast    = 1'b0;
      strobe  = 1'b0;
      zero    = 1'b0;
      chk(name, 4'd0);
      @(negedge clk) reset_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      reset_n = 1'b0;
      fast    = 1'b0;
      minus   = 1'b0;
      plus    = 1'b0;
      strobe  = 1'b0;
      spin_in = '0;
      zero    = 1'b0;

      chk("reset", 4'd0);
      @(negedge clk) reset_n = 1'b1;
      @(negedge clk);

      // Digital rotation: 4 slow steps then 4 fast steps
      plus = 1'b1;
      pulses(4);
      chk("slow4", 4'd2);
      fast = 1'b1;
      pulses(4);
      chk("fast4", 4'd6);
      repeat (5) @(negedge clk);
      chk("hold_no_strobe", 4'd6);

      // Counter-clockwise wrap, both-pressed cancel
      do_reset("reset_mid1");
      minus = 1'b1;
      pulse();
      chk("minus_wrap", 4'd15);
      plus = 1'b1;
      pulses(3);
      chk("both_pressed", 4'd15);
      plus = 1'b0;
      fast = 1'b1;
      pulse();
      chk("minus_fast", 4'd14);

      // Spinner deltas
      do_reset("reset_mid2");
      spin(8'd3);
      chk("spin_first", 4'd0);
      spin(8'd3);
      chk("spin_pos", 4'd1);
      spin(8'hFA);
      chk("spin_neg", 4'd0);
      spin(8'hFF);
      chk("spin_wrap", 4'd15);
      @(negedge clk) spin_in = {tog, 8'h40};
      chk("spin_no_toggle", 4'd15);

      // Toggle already present at reset release is swallowed by arming
      @(negedge clk);
      tog     = 1'b1;
      spin_in = {tog, 8'h7F};
      do_reset("reset_mid3");
      repeat (3) @(negedge clk);
      chk("arm_hold", 4'd0);
      spin(8'd4);
      chk("arm_next", 4'd1);

      // Strobe edge and spinner toggle in the same clock, then zero
      do_reset("reset_mid4");
      @(negedge clk);
      plus    = 1'b1;
      strobe  = 1'b1;
      tog     = ~tog;
      spin_in = {tog, 8'd4};
      @(negedge clk) strobe = 1'b0;
      chk("same_clk", 4'd1);
      @(negedge clk);
      zero    = 1'b1;
      strobe  = 1'b1;
      tog     = ~tog;
      spin_in = {tog, 8'd4};
      @(negedge clk);
      zero   = 1'b0;
      strobe = 1'b0;
      chk("zero_discard", 4'd0);
      pulses(2);
      chk("post_zero", 4'd1);

      // Long hold: constant rate, or accelerating when enabled
      do_reset("reset_mid5");
      plus = 1'b1;
      pulses(20);
`ifdef DIAL_ACCEL_EN
      chk("hold20", 4'd4);
`else
      chk("hold20", 4'd10);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
